lsu_ld_pcx_arb: RTL and testbench
=================================

Name: lsu_ld_pcx_arb

Overview:
- Downstream stage of the per-thread load miss queues and their 4:1 packet mux.
- Picks one of NTHR threads' pending loads round-robin and drives the one-hot `ld_pcx_rq_sel` that steers the upstream mux.
- Captures the selected `load_pcx_pkt` into an output register and holds it until PCX grants it.
- Issues are throttled by a PCX queue credit counter; speculative kills cancel a held packet before grant.

Parameters:
- PKT_W, 109, width of a load PCX packet (LMQ width).
- NTHR, 4, number of threads / LMQ entries.
- CREDITS, 2, PCX destination queue depth available to loads.

Ports:
- clk  in  1  core clock.
- arst_l  in  1  asynchronous active-low reset.
- lmq_pend  in  NTHR  thread has a valid load waiting in its LMQ.
- ld_kill  in  NTHR  speculative-pick kill per thread (w2 stage).
- load_pcx_pkt  in  PKT_W  mux output; combinationally reflects `ld_pcx_rq_sel`.
- ld_pcx_rq_sel  out  NTHR  one-hot thread select, combinational, zero when no pick.
- pcx_req_vld  out  1  output register holds a packet for PCX.
- pcx_pkt  out  PKT_W  registered packet to PCX.
- pcx_grant  in  1  PCX accepts `pcx_pkt` this cycle; valid only with `pcx_req_vld`.
- pcx_credit_ret  in  1  PCX frees one queue entry.
- ld_issued  out  NTHR  one-cycle pulse, thread's load was granted.
- credit_ovf  out  1  sticky error: credit returned while the counter is already full.

Behaviour:
- Reset (arst_l low, asynchronous):
  - `pcx_req_vld` = 0, `pcx_pkt` = 0, `ld_issued` = 0, `credit_ovf` = 0.
  - credit_cnt = CREDITS, rr_ptr = 0, held_thr = 0.
- Eligible threads: `lmq_pend` & ~`ld_kill` & ~(held-thread bit when `pcx_req_vld`).
- Slot free this cycle when either holds:
  - `pcx_req_vld` = 0 and credit_cnt > 0; or
  - `pcx_grant` = 1 and (credit_cnt − 1 + `pcx_credit_ret`) > 0.
- Pick: when the slot is free and any thread is eligible, `ld_pcx_rq_sel` = first eligible thread searching from rr_ptr upward with wrap; otherwise 0.
- Capture on the pick edge:
  - `pcx_pkt` <= `load_pcx_pkt`, `pcx_req_vld` <= 1, held_thr <= picked.
  - rr_ptr <= picked+1 mod NTHR.
  - Latency: pick to `pcx_req_vld` = 1 cycle.
- Hold: `pcx_pkt` and `pcx_req_vld` stay stable until grant or kill.
- Grant:
  - `ld_issued`[held_thr] pulses the next cycle.
  - credit_cnt decrements, net of a same-cycle `pcx_credit_ret` (grant + ret = no change).
  - With no back-to-back pick, `pcx_req_vld` falls the next cycle.
- Kill:
  - `ld_kill`[held_thr] with `pcx_req_vld` and no grant → `pcx_req_vld` <= 0 next cycle.
  - No `ld_issued` pulse and no credit change.
  - The killed thread is not re-picked in the kill cycle. It may be picked on a later cycle if `lmq_pend` is still set.
- Grant and kill in the same cycle: grant wins; the packet counts as issued.
- Credits:
  - credit_cnt is $clog2(CREDITS+1) bits and saturates at CREDITS.
  - `pcx_credit_ret` at full → `credit_ovf` <= 1, sticky until reset.
  - `pcx_credit_ret` at full with a simultaneous grant is legal: counter stays full, no overflow.
- Credit starvation: at credit_cnt = 0 no pick occurs and `ld_pcx_rq_sel` = 0.
- `pcx_grant` without `pcx_req_vld` is ignored.
- Reset mid-hold: the packet is dropped with no `ld_issued` pulse; credits restore to CREDITS.

Test Plan:
- Single thread: reset, `lmq_pend` = 4'b0100, pkt = 0xABC. Expect:
  - `ld_pcx_rq_sel` = 4'b0100 in cycle 0.
  - `pcx_req_vld` = 1 with `pcx_pkt` = 0xABC in cycle 1.
  - Grant in cycle 3 → `ld_issued` = 4'b0100 in cycle 4.
- Round-robin: `lmq_pend` = 4'b1111 held, grant every cycle, `pcx_credit_ret` every cycle. Expect:
  - Select order 0001, 0010, 0100, 1000, 0001.
  - `pcx_req_vld` continuous.
- Credit limit: `lmq_pend` = 4'b0011, grants immediate, no returns. Expect:
  - Two issues, then `ld_pcx_rq_sel` = 0.
  - One `pcx_credit_ret` → third pick the following cycle.
- Kill:
  - Thread 1 held, `ld_kill` = 4'b0010 without grant → `pcx_req_vld` 0 next cycle, no `ld_issued`, credit_cnt unchanged (2).
  - Repeat with grant in the same cycle → `ld_issued` = 4'b0010.
- Overflow: at credit_cnt = 2 pulse `pcx_credit_ret` → `credit_ovf` = 1 and stays 1 until `arst_l` low.
- Async reset: assert `arst_l` low mid-clock while `pcx_req_vld` = 1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lsu_ld_pcx_arb.sv
// Load PCX issue arbiter: round-robin pick across per-thread LMQs, one-deep
// output register held until PCX grant, credit-throttled, speculative kill.
module lsu_ld_pcx_arb #(
    parameter int unsigned PKT_W   = 109,
    parameter int unsigned NTHR    = 4,
    parameter int unsigned CREDITS = 2
) (
    input  logic             clk,
    input  logic             arst_l,
    input  logic [NTHR-1:0]  lmq_pend,
    input  logic [NTHR-1:0]  ld_kill,
    input  logic [PKT_W-1:0] load_pcx_pkt,
    output logic [NTHR-1:0]  ld_pcx_rq_sel,
    output logic             pcx_req_vld,
    output logic [PKT_W-1:0] pcx_pkt,
    input  logic             pcx_grant,
    input  logic             pcx_credit_ret,
    output logic [NTHR-1:0]  ld_issued,
    output logic             credit_ovf
);

    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam int unsigned TW = (NTHR > 1) ? $clog2(NTHR) : 1;
    localparam int unsigned AW = CW + 1;

    logic             vld_q,    vld_d;
    logic [PKT_W-1:0] pkt_q,    pkt_d;
    logic [TW-1:0]    held_q,   held_d;
    logic [TW-1:0]    rr_q,     rr_d;
    logic [CW-1:0]    cred_q,   cred_d;
    logic             ovf_q,    ovf_d;
    logic [NTHR-1:0]  issued_q, issued_d;

    logic             grant_eff;
    logic             kill_held;
    logic             slot_free;
    logic             pick_vld;
    logic [TW-1:0]    pick_idx;
    logic [NTHR-1:0]  held_oh;
    logic [NTHR-1:0]  elig;
    logic [AW-1:0]    cred_sum;
    int unsigned      idx;

    // Pick and next-state: a grant frees the register for a same-cycle refill.
    always_comb begin
        grant_eff = pcx_grant & vld_q;
        held_oh   = NTHR'(1) << held_q;
        kill_held = vld_q & (|(ld_kill & held_oh)) & ~grant_eff;
        elig      = lmq_pend & ~ld_kill & ~(vld_q ? held_oh : '0);
        cred_sum  = AW'(cred_q) + AW'(pcx_credit_ret) - AW'(grant_eff);
        slot_free = (~vld_q & (cred_q != '0)) | (grant_eff & (cred_sum != '0));

        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        if (slot_free) begin
            for (int unsigned k = 0; k < NTHR; k++) begin
                idx = (32'(rr_q) + k) % NTHR;
                if (!pick_vld && elig[TW'(idx)]) begin
                    pick_vld = 1'b1;
                    pick_idx = TW'(idx);
                end
            end
        end

        ld_pcx_rq_sel = pick_vld ? (NTHR'(1) << pick_idx) : '0;

        vld_d    = vld_q;
        pkt_d    = pkt_q;
        held_d   = held_q;
        rr_d     = rr_q;
        ovf_d    = ovf_q;
        issued_d = grant_eff ? held_oh : '0;

        if (pick_vld) begin
            vld_d  = 1'b1;
            pkt_d  = load_pcx_pkt;
            held_d = pick_idx;
            rr_d   = (pick_idx == TW'(NTHR - 1)) ? '0 : pick_idx + TW'(1);
        end else if (grant_eff || kill_held) begin
            vld_d = 1'b0;
        end

        // A return while already full saturates and flags the overflow.
        if (cred_sum > AW'(CREDITS)) begin
            cred_d = CW'(CREDITS);
            ovf_d  = 1'b1;
        end else begin
            cred_d = CW'(cred_sum);
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            vld_q    <= 1'b0;
            pkt_q    <= '0;
            held_q   <= '0;
            rr_q     <= '0;
            cred_q   <= CW'(CREDITS);
            ovf_q    <= 1'b0;
            issued_q <= '0;
        end else begin
            vld_q    <= vld_d;
            pkt_q    <= pkt_d;
            held_q   <= held_d;
            rr_q     <= rr_d;
            cred_q   <= cred_d;
            ovf_q    <= ovf_d;
            issued_q <= issued_d;
        end
    end

    assign pcx_req_vld = vld_q;
    assign pcx_pkt     = pkt_q;
    assign ld_issued   = issued_q;
    assign credit_ovf  = ovf_q;

endmodule

// File: tb/tb_lsu_ld_pcx_arb.sv
// Scoreboard bench for lsu_ld_pcx_arb: a cycle-level model predicts picks,
// captures and issues; a monitor pops expectations as the DUT presents them.
module tb_lsu_ld_pcx_arb;

    localparam int PKT_W   = 109;
    localparam int NTHR    = 4;
    localparam int CREDITS = 2;

    typedef struct {
        int               thr;
        logic [PKT_W-1:0] pkt;
    } cap_t;

    logic             clk            = 1'b0;
    logic             arst_l         = 1'b0;
    logic [NTHR-1:0]  lmq_pend       = '0;
    logic [NTHR-1:0]  ld_kill        = '0;
    logic [PKT_W-1:0] load_pcx_pkt;
    logic [NTHR-1:0]  ld_pcx_rq_sel;
    logic             pcx_req_vld;
    logic [PKT_W-1:0] pcx_pkt;
    logic             pcx_grant      = 1'b0;
    logic             pcx_credit_ret = 1'b0;
    logic [NTHR-1:0]  ld_issued;
    logic             credit_ovf;

    logic [PKT_W-1:0] pkt_mem [NTHR];

    int checks = 0;
    int errors = 0;

    bit m_vld;
    bit m_ovf;
    int m_held;
    int m_rr;
    int m_cred;

    cap_t cap_q[$];
    int   iss_q[$];

    always #5 clk = ~clk;

    lsu_ld_pcx_arb #(.PKT_W(PKT_W), .NTHR(NTHR), .CREDITS(CREDITS)) dut (
        .clk            (clk),
        .arst_l         (arst_l),
        .lmq_pend       (lmq_pend),
        .ld_kill        (ld_kill),
        .load_pcx_pkt   (load_pcx_pkt),
        .ld_pcx_rq_sel  (ld_pcx_rq_sel),
        .pcx_req_vld    (pcx_req_vld),
        .pcx_pkt        (pcx_pkt),
        .pcx_grant      (pcx_grant),
        .pcx_credit_ret (pcx_credit_ret),
        .ld_issued      (ld_issued),
        .credit_ovf     (credit_ovf)
    );

    // Upstream LMQ mux, steered by the DUT's select.
    always_comb begin
        load_pcx_pkt = '0;
        for (int t = 0; t < NTHR; t++)
            if (ld_pcx_rq_sel[t]) load_pcx_pkt = load_pcx_pkt | pkt_mem[t];
    end

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[PKT_W-1:0];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_held = 0;
        m_rr   = 0;
        m_cred = CREDITS;
        cap_q.delete();
        iss_q.delete();
    endtask

    // One clock of stimulus; the model predicts this cycle's select and the
    // responses that should appear after the next rising edge.
    task automatic step(input logic [NTHR-1:0] pend, input logic [NTHR-1:0] kill,
                        input logic grant, input logic ret, input bit rnd_pkt);
        bit              g;
        bit              slot;
        int              pick;
        int              t;
        logic [NTHR-1:0] es;
        cap_t            c;
        @(negedge clk);
        if (rnd_pkt)
            for (int i = 0; i < NTHR; i++) pkt_mem[i] = rand_pkt();
        lmq_pend       = pend;
        ld_kill        = kill;
        pcx_grant      = grant;
        pcx_credit_ret = ret;
        #1;
        check("req_vld", 128'(pcx_req_vld), 128'(m_vld));
        check("credit_ovf", 128'(credit_ovf), 128'(m_ovf));

        g    = m_vld && grant;
        slot = (!m_vld && m_cred > 0) || (g && (m_cred - 1 + int'(ret)) > 0);
        pick = -1;
        if (slot) begin
            for (int k = 0; k < NTHR; k++) begin
                t = (m_rr + k) % NTHR;
                if (pick < 0 && pend[t] && !kill[t] && !(m_vld && t == m_held)) pick = t;
            end
        end
        es = '0;
        if (pick >= 0) es[pick] = 1'b1;
        check("rq_sel", 128'(ld_pcx_rq_sel), 128'(es));

        if (g) iss_q.push_back(m_held);
        if (pick >= 0) begin
            c.thr = pick;
            c.pkt = pkt_mem[pick];
            cap_q.push_back(c);
        end

        m_cred = m_cred - int'(g) + int'(ret);
        if (m_cred > CREDITS) begin
            m_cred = CREDITS;
            m_ovf  = 1'b1;
        end
        if (pick >= 0) begin
            m_vld  = 1'b1;
            m_held = pick;
            m_rr   = (pick + 1) % NTHR;
        end else if (g || (m_vld && kill[m_held])) begin
            m_vld = 1'b0;
        end
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(posedge clk);
        #3;
        arst_l         = 1'b0;
        lmq_pend       = '0;
        ld_kill        = '0;
        pcx_grant      = 1'b0;
        pcx_credit_ret = 1'b0;
        #1;
        check("rst_req_vld", 128'(pcx_req_vld), 128'(0));
        check("rst_pcx_pkt", 128'(pcx_pkt), 128'(0));
        check("rst_ld_issued", 128'(ld_issued), 128'(0));
        check("rst_credit_ovf", 128'(credit_ovf), 128'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        arst_l = 1'b1;
    endtask

    // Monitor: consumes expected captures/issues as the DUT presents them.
    initial begin
        bit   prev_vld;
        bit   prev_grant;
        cap_t c;
        int   e;
        prev_vld = 1'b0;
        forever begin
            @(posedge clk);
            prev_grant = pcx_grant;
            #1;
            if (arst_l !== 1'b1) begin
                prev_vld = 1'b0;
            end else begin
                if (cap_q.size() > 0) begin
                    c = cap_q.pop_front();
                    check("capture_vld", 128'(pcx_req_vld), 128'(1));
                    check("capture_pkt", 128'(pcx_pkt), 128'(c.pkt));
                end else if (pcx_req_vld && (!prev_vld || prev_grant)) begin
                    errors++;
                    $display("FAIL unexpected_capture: got pkt %0h expected none at %0t", pcx_pkt, $time);
                end
                if (iss_q.size() > 0) begin
                    e = iss_q.pop_front();
                    check("ld_issued", 128'(ld_issued), 128'(1) << e);
                end else begin
                    check("ld_issued_idle", 128'(ld_issued), 128'(0));
                end
                prev_vld = pcx_req_vld;
            end
        end
    end

    initial begin
        logic [NTHR-1:0] rr_exp [5];
        logic [NTHR-1:0] rp;
        logic [NTHR-1:0] rk;
        logic            rg;
        logic            rt;
        for (int i = 0; i < NTHR; i++) pkt_mem[i] = rand_pkt();
        model_reset();
        do_reset();

        // Single thread with a late grant.
        pkt_mem[2] = PKT_W'(12'hABC);
        step(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("single_sel", 128'(ld_pcx_rq_sel), 128'(4'b0100));
        step(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("single_pkt", 128'(pcx_pkt), 128'(12'hABC));
        step(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("single_issued", 128'(ld_issued), 128'(4'b0100));
        step(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);

        // Round robin with grant and return every cycle.
        do_reset();
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("rr_order0", 128'(ld_pcx_rq_sel), 128'(rr_exp[0]));
        for (int i = 1; i < 5; i++) begin
            step(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1);
            check("rr_order", 128'(ld_pcx_rq_sel), 128'(rr_exp[i]));
        end
        step(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Credit exhaustion and recovery.
        do_reset();
        step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b1);
        step(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b1);
        check("credit_stall", 128'(ld_pcx_rq_sel), 128'(0));
        step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0011, 4'b0000, 1'b0, 1'b1, 1'b1);
        check("credit_stall_ret", 128'(ld_pcx_rq_sel), 128'(0));
        step(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("credit_resume", 128'(ld_pcx_rq_sel), 128'(4'b0001));
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Kill without and with a same-cycle grant.
        do_reset();
        step(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1);
        check("kill_no_repick", 128'(ld_pcx_rq_sel), 128'(0));
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("kill_drop", 128'(pcx_req_vld), 128'(0));
        step(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("kill_repick", 128'(ld_pcx_rq_sel), 128'(4'b0010));
        step(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("kill_grant_issued", 128'(ld_issued), 128'(4'b0010));

        // Overflow is sticky until reset.
        do_reset();
        step(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        check("ovf_sticky", 128'(credit_ovf), 128'(1));

        // Reset while a packet is held.
        do_reset();
        step(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("hold_before_reset", 128'(pcx_req_vld), 128'(1));
        do_reset();

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            rp = NTHR'($urandom);
            rk = ($urandom_range(0, 3) == 0) ? NTHR'($urandom) : '0;
            rg = ($urandom_range(0, 2) != 0);
            rt = (m_cred < CREDITS) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) rt = 1'b1;
            step(rp, rk, rg, rt, 1'b1);
            if (n == 1000) do_reset();
        end
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        check("cap_q_drained", 128'(cap_q.size()), 128'(0));
        check("iss_q_drained", 128'(iss_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
